ssd_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 4-digit seven-segment display.
- Holds a 16-bit display value and cycles through the four digits at a programmable refresh rate.
- Each scan step presents one hex nibble and a 2-bit digit select to the seven-segment decoder (digit select drives the decoder enable; num drives the decoder nibble).
- New values are accepted through a load/ack handshake and applied only at frame boundaries, so the display never tears mid-frame.

---
 rtl/ssd_scan_ctrl.sv | 115 +++++++++++
 tb/tb_ssd_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - time-multiplexed scan controller for a 4-digit seven-segment display
//
// Purpose: holds a 16-bit display value and steps through its four hex
// digits, holding each one for REFRESH_DIV cycles. A new value is loaded
// into a pending register and moved to the display only at a frame
// boundary, so a frame never mixes digits from two different values.
//
// Optional build macro: SSD_LEADING_ZERO_BLANK_EN
//   defined     - blank marks leading zero digits (digit 0 always lit)
//   not defined - blank is tied to 0
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   load       in   1   capture value into the pending register (level)
//   value      in  16   value to show; nibble 0 = rightmost digit
//   digit_sel  out  2   digit currently driven (0 = rightmost)
//   num        out  4   nibble of the selected digit
//   blank      out  1   selected digit should be dark
//   pending    out  1   a loaded value waits for the next frame boundary
//   load_ack   out  1   one-cycle pulse: pending value reached the display
//   frame_tick out  1   one-cycle pulse at each frame start
module ssd_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  output logic [1:0]  digit_sel,
  output logic [3:0]  num,
  output logic        blank,
  output logic        pending,
  output logic        load_ack,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] prescaler;
  logic [15:0]      display;
  logic [15:0]      pend_val;
  logic             tc;
  logic             boundary;
  logic             transfer;

  assign tc       = (prescaler == TC_VAL);
  assign boundary = tc && (digit_sel == 2'd3);
  // Transfer decision uses pending as it stood before this edge, so a load
  // landing on the boundary cycle cannot jump ahead of the older value.
  assign transfer = boundary && pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler  <= '0;
      digit_sel  <= 2'd0;
      display    <= 16'h0000;
      pend_val   <= 16'h0000;
      pending    <= 1'b0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      if (tc) begin
        prescaler <= '0;
        digit_sel <= digit_sel + 2'd1;
      end else begin
        prescaler <= prescaler + CNT_ONE;
      end

      frame_tick <= boundary;
      load_ack   <= transfer;

      if (transfer)
        display <= pend_val;

      // A load on the transfer edge refills the pending slot, so load wins
      // over the clear.
      if (load) begin
        pend_val <= value;
        pending  <= 1'b1;
      end else if (transfer) begin
        pending  <= 1'b0;
      end
    end
  end

  always_comb begin
    num = 4'h0;
    case (digit_sel)
      2'd0: num = display[3:0];
      2'd1: num = display[7:4];
      2'd2: num = display[11:8];
      2'd3: num = display[15:12];
      default: num = 4'h0;
    endcase
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A digit is dark when it and all digits to its left are zero.
  always_comb begin
    blank = 1'b0;
    case (digit_sel)
      2'd3: blank = (display[15:12] == 4'h0);
      2'd2: blank = (display[15:8] == 8'h00);
      2'd1: blank = (display[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - directed self-checking bench for ssd_scan_ctrl
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [1:0]  digit_sel;
  logic [3:0]  num;
  logic        blank;
  logic        pending;
  logic        load_ack;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;
  int n = 0;  // rising edges since the last reset release

`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam logic BL = 1'b1;
`else
  localparam logic BL = 1'b0;
`endif

  ssd_scan_ctrl #(.REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .digit_sel(digit_sel), .num(num), .blank(blank), .pending(pending),
    .load_ack(load_ack), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic tick_to(input int target);
    while (n < target) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({digit_sel, num, blank, pending, load_ack, frame_tick} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got ds=%0d num=%h bl=%b pd=%b ack=%b ft=%b want all 0",
               digit_sel, num, blank, pending, load_ack, frame_tick);
    end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (digit_sel !== 2'((n / 4) % 4) || num !== 4'h0) begin
        failures++;
        $display("FAIL scan_step n=%0d got ds=%0d num=%h want ds=%0d num=0",
                 n, digit_sel, num, (n / 4) % 4);
      end
      checks++;
      if (frame_tick !== ((n % 16) == 0)) begin
        failures++;
        $display("FAIL frame_tick n=%0d got %b want %b", n, frame_tick, (n % 16) == 0);
      end
    end
  endtask

  task automatic test_load();
    load = 1'b1; value = 16'h1A2F;
    tick();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1 || load_ack !== 1'b0) begin
      failures++;
      $display("FAIL load_pending got pd=%b ack=%b want pd=1 ack=0", pending, load_ack);
    end
    tick_to(32);
    checks++;
    if (load_ack !== 1'b1 || pending !== 1'b0 || frame_tick !== 1'b1 || num !== 4'hF) begin
      failures++;
      $display("FAIL load_transfer got ack=%b pd=%b ft=%b num=%h want ack=1 pd=0 ft=1 num=f",
               load_ack, pending, frame_tick, num);
    end
    tick();
    checks++;
    if (load_ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_one_cycle got %b want 0", load_ack);
    end
    tick_to(36);
    checks++;
    if (num !== 4'h2) begin failures++; $display("FAIL load_d1 got %h want 2", num); end
    tick_to(40);
    checks++;
    if (num !== 4'hA) begin failures++; $display("FAIL load_d2 got %h want a", num); end
    tick_to(44);
    checks++;
    if (num !== 4'h1 || digit_sel !== 2'd3) begin
      failures++;
      $display("FAIL load_d3 got num=%h ds=%0d want num=1 ds=3", num, digit_sel);
    end
  endtask

  task automatic test_double_load();
    int acks;
    acks = 0;
    tick_to(49);
    load = 1'b1; value = 16'h1111;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; value = 16'h2222;
    tick();
    load = 1'b0;
    while (n < 80) begin
      tick();
      if (load_ack === 1'b1) acks++;
      if (n == 64 || n == 68 || n == 72 || n == 76) begin
        checks++;
        if (num !== 4'h2) begin
          failures++;
          $display("FAIL double_load_num n=%0d got %h want 2", n, num);
        end
      end
    end
    checks++;
    if (acks !== 1) begin
      failures++;
      $display("FAIL double_load_acks got %0d want 1", acks);
    end
  endtask

  task automatic test_boundary_load();
    load = 1'b1; value = 16'h4444;
    tick();
    load = 1'b0;
    tick_to(95);
    load = 1'b1; value = 16'h3333;
    tick();
    load = 1'b0;
    checks++;
    if (load_ack !== 1'b1 || pending !== 1'b1 || num !== 4'h4) begin
      failures++;
      $display("FAIL boundary_first got ack=%b pd=%b num=%h want ack=1 pd=1 num=4",
               load_ack, pending, num);
    end
    tick();
    checks++;
    if (load_ack !== 1'b0 || pending !== 1'b1) begin
      failures++;
      $display("FAIL boundary_hold got ack=%b pd=%b want ack=0 pd=1", load_ack, pending);
    end
    tick_to(108);
    checks++;
    if (num !== 4'h4) begin failures++; $display("FAIL boundary_d3 got %h want 4", num); end
    tick_to(112);
    checks++;
    if (load_ack !== 1'b1 || pending !== 1'b0 || num !== 4'h3) begin
      failures++;
      $display("FAIL boundary_second got ack=%b pd=%b num=%h want ack=1 pd=0 num=3",
               load_ack, pending, num);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    tick_to(120);
    load = 1'b1; value = 16'h5555;
    tick();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1 || digit_sel !== 2'd2) begin
      failures++;
      $display("FAIL mid_pre got pd=%b ds=%0d want pd=1 ds=2", pending, digit_sel);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({digit_sel, num, blank, pending, load_ack, frame_tick} !== 10'b0) begin
      failures++;
      $display("FAIL mid_reset got ds=%0d num=%h bl=%b pd=%b ack=%b ft=%b want all 0",
               digit_sel, num, blank, pending, load_ack, frame_tick);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    while (n < 40) begin
      tick();
      if (load_ack === 1'b1) acks++;
      if (n == 16) begin
        checks++;
        if (frame_tick !== 1'b1 || num !== 4'h0 || pending !== 1'b0) begin
          failures++;
          $display("FAIL mid_restart got ft=%b num=%h pd=%b want ft=1 num=0 pd=0",
                   frame_tick, num, pending);
        end
      end
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL mid_no_ack got %0d want 0", acks);
    end
  endtask

  task automatic test_blank();
    load = 1'b1; value = 16'h00A5;
    tick();
    load = 1'b0;
    tick_to(48);
    checks++;
    if (blank !== 1'b0 || num !== 4'h5) begin
      failures++;
      $display("FAIL blank_a5_d0 got bl=%b num=%h want bl=0 num=5", blank, num);
    end
    tick_to(52);
    checks++;
    if (blank !== 1'b0 || num !== 4'hA) begin
      failures++;
      $display("FAIL blank_a5_d1 got bl=%b num=%h want bl=0 num=a", blank, num);
    end
    tick_to(56);
    checks++;
    if (blank !== BL) begin failures++; $display("FAIL blank_a5_d2 got %b want %b", blank, BL); end
    tick_to(60);
    checks++;
    if (blank !== BL) begin failures++; $display("FAIL blank_a5_d3 got %b want %b", blank, BL); end
    load = 1'b1; value = 16'h0000;
    tick();
    load = 1'b0;
    tick_to(64);
    checks++;
    if (blank !== 1'b0 || load_ack !== 1'b1) begin
      failures++;
      $display("FAIL blank_0_d0 got bl=%b ack=%b want bl=0 ack=1", blank, load_ack);
    end
    tick_to(68);
    checks++;
    if (blank !== BL) begin failures++; $display("FAIL blank_0_d1 got %b want %b", blank, BL); end
    tick_to(72);
    checks++;
    if (blank !== BL) begin failures++; $display("FAIL blank_0_d2 got %b want %b", blank, BL); end
    tick_to(76);
    checks++;
    if (blank !== BL) begin failures++; $display("FAIL blank_0_d3 got %b want %b", blank, BL); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_double_load();
    test_boundary_load();
    test_reset_mid();
    test_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
